i2c_register_file: RTL and testbench

Native register storage for the I2C master peripheral. Sits directly downstream of the register map stage: it takes per-register write strobes and write data from the map and returns read data for every register. Toward the I2C engine it drives configuration and control, latches received bytes, counts transferred bytes, holds sticky status flags and produces a level interrupt.

---
 rtl/i2c_register_file_if.sv | 13 +
 rtl/i2c_register_file.sv | 123 ++++++++++++
 tb/tb_i2c_register_file.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_register_file_if.sv
// Register-map side bus of the I2C register file: one write strobe per
// register, shared write data, and the packed read-back of every register.
interface i2c_register_file_if #(
    parameter int REGS   = 9,
    parameter int DATA_W = 32
);
    logic [REGS-1:0]        reg_we;
    logic [DATA_W-1:0]      reg_wdata;
    logic [REGS*DATA_W-1:0] reg_rdata;

    modport master (output reg_we, output reg_wdata, input reg_rdata);
    modport slave  (input reg_we, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/i2c_register_file.sv
// Register storage for the I2C master: config/control toward the engine,
// received byte latch, saturating byte counters, sticky status and level irq.
module i2c_register_file #(
    parameter int REGS   = 9,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_register_file_if.slave   bus,
    output logic [7:0]           tx_data,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 tx_done,
    output logic [DATA_W-1:0]    read_len,
    output logic [DATA_W-1:0]    write_len,
    output logic [15:0]          clk_div,
    output logic [7:0]           irq_en,
    output logic                 fifo_en,
    output logic                 xfer_rd,
    output logic                 start,
    output logic                 m_ack,
    output logic                 m_nack,
    output logic                 rep_start,
    input  logic                 start_ack,
    input  logic [5:0]           status_set,
    input  logic                 bus_free,
    input  logic                 arb_lost,
    output logic                 irq
);
    localparam int START_BIT = 10;

    logic [7:0]        data_out;
    logic [7:0]        data_in;
    logic [DATA_W-1:0] rlen_q;
    logic [DATA_W-1:0] wlen_q;
    logic [15:0]       clk_div_q;
    logic [13:0]       ctrl;
    logic [5:0]        status;
    logic [DATA_W-1:0] rd_cnt;
    logic [DATA_W-1:0] wr_cnt;
    logic [7:0]        status_full;

    // Reg 1, 7 and 8 are read-only, so their strobes are intentionally dropped.
    logic unused_we;
    assign unused_we = ^{bus.reg_we[1], bus.reg_we[8:7]};

    assign status_full = {arb_lost, bus_free, status};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            data_in   <= '0;
            rlen_q    <= '0;
            wlen_q    <= '0;
            clk_div_q <= '0;
            ctrl      <= '0;
        end else begin
            if (bus.reg_we[0]) data_out  <= bus.reg_wdata[7:0];
            if (rx_valid)      data_in   <= rx_data;
            if (bus.reg_we[2]) rlen_q    <= bus.reg_wdata;
            if (bus.reg_we[3]) wlen_q    <= bus.reg_wdata;
            if (bus.reg_we[4]) clk_div_q <= bus.reg_wdata[15:0];
            // A software write of START beats a simultaneous engine acknowledge.
            if (bus.reg_we[5])  ctrl            <= bus.reg_wdata[13:0];
            else if (start_ack) ctrl[START_BIT] <= 1'b0;
        end
    end

    // Hardware set pulses dominate a same-cycle software write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               status <= '0;
        else if (bus.reg_we[6])  status <= bus.reg_wdata[5:0] | status_set;
        else                     status <= status | status_set;
    end

    // Counters clear on start_ack (clear beats increment) and stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (start_ack) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rx_valid && !(&rd_cnt)) rd_cnt <= rd_cnt + DATA_W'(1);
            if (tx_done  && !(&wr_cnt)) wr_cnt <= wr_cnt + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(status_full & ctrl[7:0]);
    end

    logic [REGS-1:0][DATA_W-1:0] rd;

    always_comb begin
        rd        = '0;
        rd[0][7:0]  = data_out;
        rd[1][7:0]  = data_in;
        rd[2]       = rlen_q;
        rd[3]       = wlen_q;
        rd[4][15:0] = clk_div_q;
        rd[5][13:0] = ctrl;
        rd[6][7:0]  = status_full;
        rd[7]       = rd_cnt;
        rd[8]       = wr_cnt;
    end

    assign bus.reg_rdata = rd;

    assign tx_data   = data_out;
    assign read_len  = rlen_q;
    assign write_len = wlen_q;
    assign clk_div   = clk_div_q;
    assign irq_en    = ctrl[7:0];
    assign fifo_en   = ctrl[8];
    assign xfer_rd   = ctrl[9];
    assign start     = ctrl[START_BIT];
    assign m_ack     = ctrl[11];
    assign m_nack    = ctrl[12];
    assign rep_start = ctrl[13];
endmodule

// File: tb/tb_i2c_register_file.sv
// Bench for i2c_register_file: reset, write/read table, hand-written corner
// sequences, then random traffic against a register-image model.
module tb_i2c_register_file;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_register_file_if bus ();

    logic [7:0]  tx_data, rx_data, irq_en;
    logic        rx_valid, tx_done, start_ack, bus_free, arb_lost, irq;
    logic [31:0] read_len, write_len;
    logic [15:0] clk_div;
    logic        fifo_en, xfer_rd, start, m_ack, m_nack, rep_start;
    logic [5:0]  status_set;

    i2c_register_file dut (
        .clk(clk), .reset(reset), .bus(bus),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done),
        .read_len(read_len), .write_len(write_len), .clk_div(clk_div), .irq_en(irq_en),
        .fifo_en(fifo_en), .xfer_rd(xfer_rd), .start(start), .m_ack(m_ack),
        .m_nack(m_nack), .rep_start(rep_start), .start_ack(start_ack),
        .status_set(status_set), .bus_free(bus_free), .arb_lost(arb_lost), .irq(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int k);
        return bus.reg_rdata[k*32 +: 32];
    endfunction

    task automatic idle();
        bus.reg_we = '0; bus.reg_wdata = '0;
        rx_data = '0; rx_valid = 0; tx_done = 0; start_ack = 0;
        status_set = '0; bus_free = 0; arb_lost = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input int k, input logic [31:0] d);
        bus.reg_we = 9'(1) << k;
        bus.reg_wdata = d;
        @(negedge clk);
        bus.reg_we = '0;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[9];

    // Model: software-visible image of each register, status without live bits.
    logic [31:0] m [9];
    logic        m_irq;
    logic [31:0] wmask [9];

    initial begin
        logic [31:0] nm [9];
        logic [8:0]  we;
        logic [31:0] wd;

        // ---------------- reset state ----------------
        do_reset();
        bus_free = 1'b1;
        #1;
        for (int k = 0; k < 9; k++)
            chk($sformatf("reset reg%0d", k), rd(k), (k == 6) ? 32'h40 : 32'h0);
        chk("reset irq", irq, 0);
        chk("reset outs", {tx_data, clk_div, irq_en, rep_start, m_nack, m_ack, start, xfer_rd, fifo_en}, 0);
        chk("reset lens", {read_len, write_len}, 0);
        bus_free = 1'b0;

        // ---------------- write/readback table ----------------
        vecs[0] = '{4, 32'hDEAD_BEEF, 32'h0000_BEEF};
        vecs[1] = '{0, 32'hDEAD_BEEF, 32'h0000_00EF};
        vecs[2] = '{1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{3, 32'h1234_5678, 32'h1234_5678};
        vecs[5] = '{5, 32'hFFFF_FFFF, 32'h0000_3FFF};
        vecs[6] = '{6, 32'hFFFF_FFFF, 32'h0000_003F};
        vecs[7] = '{7, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{8, 32'hA5A5_A5A5, 32'h0000_0000};
        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].idx, vecs[i].wdata);
            chk($sformatf("table reg%0d", vecs[i].idx), rd(vecs[i].idx), vecs[i].exp);
        end
        chk("table clk_div", clk_div, 16'hBEEF);
        chk("table tx_data", tx_data, 8'hEF);
        chk("table lens", {read_len, write_len}, {32'hFFFF_FFFF, 32'h1234_5678});
        chk("table ctrl outs", {rep_start, m_nack, m_ack, start, xfer_rd, fifo_en, irq_en}, 14'h3FFF);

        // ---------------- interrupt set / clear latency ----------------
        do_reset();
        wr(5, 32'h1);
        status_set = 6'b000001;
        @(negedge clk);
        status_set = '0;
        chk("irq stat set", rd(6), 32'h1);
        chk("irq N+1", irq, 0);
        @(negedge clk);
        chk("irq N+2", irq, 1);
        wr(6, 32'h0);
        chk("irq stat clr", rd(6), 32'h0);
        chk("irq clr N+1", irq, 1);
        @(negedge clk);
        chk("irq clr N+2", irq, 0);

        // same-cycle set pulse and clearing write: set wins
        status_set = 6'b010000;
        wr(6, 32'h0);
        status_set = '0;
        chk("set beats write", rd(6), 32'h10);

        // ---------------- START and counters ----------------
        do_reset();
        wr(5, 32'h400);
        chk("start set", start, 1);
        rx_valid = 1; tx_done = 1;
        @(negedge clk); @(negedge clk);
        rx_valid = 0; tx_done = 0;
        chk("cnt rd 2", rd(7), 2);
        chk("cnt wr 2", rd(8), 2);
        start_ack = 1; rx_valid = 1; tx_done = 1;
        @(negedge clk);
        idle();
        chk("start_ack start", start, 0);
        chk("start_ack rd cnt", rd(7), 0);
        chk("start_ack wr cnt", rd(8), 0);
        start_ack = 1;
        wr(5, 32'h400);
        start_ack = 0;
        chk("write beats ack", start, 1);
        rx_data = 8'hA5; rx_valid = 1;
        repeat (3) @(negedge clk);
        rx_valid = 0;
        chk("rx reg1", rd(1), 32'hA5);
        chk("rx reg7", rd(7), 3);

        // ---------------- saturation and async reset ----------------
        force dut.wr_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wr_cnt;
        chk("sat preload", rd(8), 32'hFFFF_FFFF);
        tx_done = 1;
        @(negedge clk); @(negedge clk);
        chk("sat hold", rd(8), 32'hFFFF_FFFF);
        #2 reset = 1'b1;
        #1;
        chk("async reset reg8", rd(8), 0);
        chk("async reset reg7", rd(7), 0);
        chk("async reset start", start, 0);
        @(negedge clk);
        idle();
        reset = 1'b0;
        @(negedge clk);

        // ---------------- random traffic vs model ----------------
        wmask = '{32'hFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF, 32'h3FFF, 32'h3F, 32'h0, 32'h0};
        for (int k = 0; k < 9; k++) m[k] = '0;
        m_irq = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 9; k++)
                chk($sformatf("rand c%0d reg%0d", c, k), rd(k),
                    (k == 6) ? (m[6] | {24'h0, arb_lost, bus_free, 6'h0}) : m[k]);
            chk($sformatf("rand c%0d outs", c),
                {tx_data, clk_div, rep_start, m_nack, m_ack, start, xfer_rd, fifo_en, irq_en, irq},
                {m[0][7:0], m[4][15:0], m[5][13:0], m_irq});
            chk($sformatf("rand c%0d lens", c), {read_len, write_len}, {m[2], m[3]});

            we = 9'($urandom & $urandom);
            wd = $urandom;
            bus.reg_we = we; bus.reg_wdata = wd;
            rx_data    = 8'($urandom);
            rx_valid   = ($urandom_range(0, 2) == 0);
            tx_done    = ($urandom_range(0, 2) == 0);
            start_ack  = ($urandom_range(0, 15) == 0);
            status_set = 6'($urandom & $urandom & $urandom);
            bus_free   = 1'($urandom);
            arb_lost   = 1'($urandom);

            nm = m;
            for (int k = 0; k < 9; k++)
                if (we[k] && wmask[k] != 0) nm[k] = wd & wmask[k];
            if (rx_valid) nm[1] = {24'h0, rx_data};
            nm[6] = ((we[6] ? wd : m[6]) | {26'h0, status_set}) & 32'h3F;
            if (!we[5] && start_ack) nm[5][10] = 1'b0;
            if (start_ack) begin
                nm[7] = 0;
                nm[8] = 0;
            end else begin
                if (rx_valid && m[7] != 32'hFFFF_FFFF) nm[7] = m[7] + 1;
                if (tx_done  && m[8] != 32'hFFFF_FFFF) nm[8] = m[8] + 1;
            end
            m_irq = ((m[6][7:0] | {arb_lost, bus_free, 6'h0}) & m[5][7:0]) != 0;
            m = nm;
            @(negedge clk);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
